// File: rtl/pkt_transceiver_pkg.sv
// Shared definitions for the NoC output stage: FSM encoding, flit field
// layout, mesh direction indices and elaboration-time helpers.
package pkt_transceiver_pkg;

    // Transceiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Flit layout: {payload, tail, dest}; destination always starts at bit 0
    localparam int unsigned DEST_LSB = 0;

    // Mesh direction to network port index
    localparam int unsigned DIR_NORTH = 0;
    localparam int unsigned DIR_EAST  = 1;
    localparam int unsigned DIR_SOUTH = 2;
    localparam int unsigned DIR_WEST  = 3;

    // Total flit width on the bus
    function automatic int unsigned bus_size(int unsigned data_size, int unsigned addr_size);
        return data_size + addr_size + 1;
    endfunction

    // Bit position of the tail flag
    function automatic int unsigned tail_bit(int unsigned addr_size);
        return addr_size;
    endfunction

    // First payload bit
    function automatic int unsigned payload_lsb(int unsigned addr_size);
        return addr_size + 1;
    endfunction

    // Side length of the smallest square mesh holding the given node count
    function automatic int unsigned mesh_width(int unsigned nodes);
        int unsigned w;
        w = 1;
        while (w * w < nodes) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/pkt_transceiver_routing.sv
// Combinational XY router for a square mesh. Nodes are numbered row-major,
// x first then y. Returns the network port toward dest_sw, PORTS_NUM when
// dest_sw is this switch, and PORTS_NUM+1 for an address outside the mesh.
module pkt_transceiver_routing
    import pkt_transceiver_pkg::*;
#(
    parameter int unsigned ADDR      = 0,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned PORTS_NUM = 4,
    parameter int unsigned NODES_NUM = 9,
    parameter int unsigned PIDX_W    = 3
) (
    input  logic [ADDR_SIZE-1:0] dest_sw,
    output logic [PIDX_W-1:0]    port_num
);

    localparam int unsigned MESH_W = mesh_width(NODES_NUM);
    localparam int unsigned CUR_X  = ADDR % MESH_W;
    localparam int unsigned CUR_Y  = ADDR / MESH_W;

    int unsigned dst;
    int unsigned dst_x;
    int unsigned dst_y;

    assign dst   = 32'(dest_sw);
    assign dst_x = dst % MESH_W;
    assign dst_y = dst / MESH_W;

    // Resolve X first, then Y; invalid node ids get the error code
    always_comb begin
        if (dst >= NODES_NUM)
            port_num = PIDX_W'(PORTS_NUM + 1);
        else if (dst_x > CUR_X)
            port_num = PIDX_W'(DIR_EAST);
        else if (dst_x + 1 <= CUR_X)
            port_num = PIDX_W'(DIR_WEST);
        else if (dst_y > CUR_Y)
            port_num = PIDX_W'(DIR_SOUTH);
        else if (dst_y + 1 <= CUR_Y)
            port_num = PIDX_W'(DIR_NORTH);
        else
            port_num = PIDX_W'(PORTS_NUM);
    end

endmodule

// File: rtl/pkt_transceiver.sv
// NoC switch output stage: pops flits from the input queue, routes each
// packet head, locks the chosen port until the tail is acknowledged and
// reflects unroutable or unconnected packets to the local port.
// Optional ack timeout is enabled with the PKT_TX_TIMEOUT_EN macro.
module pkt_transceiver
    import pkt_transceiver_pkg::*;
#(
    parameter int unsigned ADDR        = 0,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned ADDR_SIZE   = 4,
    parameter int unsigned PORTS_NUM   = 4,
    parameter int unsigned NODES_NUM   = 9,
    parameter int unsigned MAX_PKT_LEN = 16,
    parameter int unsigned TIMEOUT     = 64,
    localparam int unsigned BUS_SIZE   = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                              clk,
    input  logic                              a_rst_n,
    input  logic                              mem_empty,
    input  logic [BUS_SIZE-1:0]               data_i,
    input  logic [PORTS_NUM:0]                port_conn,
    input  logic [PORTS_NUM:0]                r_ready_in,
    output logic                              mem_readed,
    output logic [PORTS_NUM:0]                wr_ready_out,
    output logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_o,
    output logic                              busy,
    output logic                              drop_err
);

    localparam int unsigned NPORTS = PORTS_NUM + 1;
    localparam int unsigned PIDX_W = $clog2(PORTS_NUM + 2);
    localparam int unsigned CNT_W  = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned TAIL   = tail_bit(ADDR_SIZE);

    state_t                      state_q, state_d;
    logic [PIDX_W-1:0]           port_l_q, port_l_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        tail_q, tail_d;

    logic                        mem_readed_d;
    logic [PORTS_NUM:0]          wr_ready_d;
    logic [BUS_SIZE*NPORTS-1:0]  data_d;
    logic                        busy_d;
    logic                        drop_err_d;

    logic [PIDX_W-1:0]           route_port;
    logic                        route_ok;
    logic                        ack_sel;
    logic                        limit_hit;

`ifdef PKT_TX_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic                        timeout_hit;

    assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT - 1));
`else
    logic                        unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
`endif

    pkt_transceiver_routing #(
        .ADDR      (ADDR),
        .ADDR_SIZE (ADDR_SIZE),
        .PORTS_NUM (PORTS_NUM),
        .NODES_NUM (NODES_NUM),
        .PIDX_W    (PIDX_W)
    ) u_routing_module (
        .dest_sw  (data_i[DEST_LSB +: ADDR_SIZE]),
        .port_num (route_port)
    );

    // Route is usable only if it names an existing port with a live link
    always_comb begin
        route_ok = 1'b0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (route_port == PIDX_W'(p) && port_conn[p])
                route_ok = 1'b1;
        end
    end

    // Ack from the locked port only; other ports' acks are ignored
    always_comb begin
        ack_sel = 1'b0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (port_l_q == PIDX_W'(p) && r_ready_in[p])
                ack_sel = 1'b1;
        end
    end

    assign limit_hit = (cnt_q == CNT_W'(MAX_PKT_LEN));

    // State register
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!mem_empty) state_d = ST_ROUTE;
            ST_ROUTE: state_d = ST_LOAD;
            ST_LOAD:  if (!mem_empty) state_d = ST_ACK;
            ST_ACK: begin
                if (ack_sel) begin
                    if (tail_q || limit_hit)
                        state_d = ST_IDLE;
                    else
                        state_d = ST_LOAD;
                end
`ifdef PKT_TX_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values for registered outputs and datapath
    always_comb begin
        mem_readed_d = 1'b0;
        drop_err_d   = 1'b0;
        wr_ready_d   = wr_ready_out;
        data_d       = data_o;
        busy_d       = busy;
        port_l_d     = port_l_q;
        cnt_d        = cnt_q;
        tail_d       = tail_q;
`ifdef PKT_TX_TIMEOUT_EN
        tmr_d        = tmr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!mem_empty) busy_d = 1'b1;
            end
            ST_ROUTE: begin
                port_l_d = route_ok ? route_port : PIDX_W'(PORTS_NUM);
                cnt_d    = '0;
            end
            ST_LOAD: begin
                if (!mem_empty) begin
                    for (int unsigned p = 0; p < NPORTS; p++) begin
                        if (port_l_q == PIDX_W'(p)) begin
                            data_d[p*BUS_SIZE +: BUS_SIZE] = data_i;
                            wr_ready_d[p]                  = 1'b1;
                        end
                    end
                    mem_readed_d = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    tail_d       = data_i[TAIL];
`ifdef PKT_TX_TIMEOUT_EN
                    tmr_d        = '0;
`endif
                end
            end
            ST_ACK: begin
                if (ack_sel) begin
                    wr_ready_d = '0;
                    if (tail_q) begin
                        busy_d = 1'b0;
                    end else if (limit_hit) begin
                        busy_d     = 1'b0;
                        drop_err_d = 1'b1;
                    end
                end
`ifdef PKT_TX_TIMEOUT_EN
                else if (timeout_hit) begin
                    wr_ready_d = '0;
                    busy_d     = 1'b0;
                    drop_err_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
`endif
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            mem_readed   <= 1'b0;
            wr_ready_out <= '0;
            data_o       <= '0;
            busy         <= 1'b0;
            drop_err     <= 1'b0;
            port_l_q     <= PIDX_W'(PORTS_NUM);
            cnt_q        <= '0;
            tail_q       <= 1'b0;
`ifdef PKT_TX_TIMEOUT_EN
            tmr_q        <= '0;
`endif
        end else begin
            mem_readed   <= mem_readed_d;
            wr_ready_out <= wr_ready_d;
            data_o       <= data_d;
            busy         <= busy_d;
            drop_err     <= drop_err_d;
            port_l_q     <= port_l_d;
            cnt_q        <= cnt_d;
            tail_q       <= tail_d;
`ifdef PKT_TX_TIMEOUT_EN
            tmr_q        <= tmr_d;
`endif
        end
    end

endmodule

// File: tb/tb_pkt_transceiver.sv
// Directed bench for pkt_transceiver on a 3x3 mesh, switch 0 at (0,0).
// From node 0: dest 0 -> local(4), dest 1/2 -> east(1), dest 3 -> south(2),
// dest >= 9 -> invalid -> local(4).
module tb_pkt_transceiver;

    localparam int unsigned DATA_SIZE   = 32;
    localparam int unsigned ADDR_SIZE   = 4;
    localparam int unsigned PORTS_NUM   = 4;
    localparam int unsigned NODES_NUM   = 9;
    localparam int unsigned MAX_PKT_LEN = 3;
    localparam int unsigned TIMEOUT     = 8;
    localparam int unsigned BUS         = DATA_SIZE + ADDR_SIZE + 1;
    localparam int unsigned NP          = PORTS_NUM + 1;

    logic              clk = 1'b0;
    logic              a_rst_n;
    logic              mem_empty;
    logic [BUS-1:0]    data_i;
    logic [NP-1:0]     port_conn;
    logic [NP-1:0]     r_ready_in;
    logic              mem_readed;
    logic [NP-1:0]     wr_ready_out;
    logic [BUS*NP-1:0] data_o;
    logic              busy;
    logic              drop_err;

    logic [BUS-1:0]    q [64];
    int                qlen = 0;
    int                pops = 0;
    logic              multi_hot = 1'b0;
    int                checks = 0;
    int                errors = 0;

    pkt_transceiver #(
        .ADDR        (0),
        .DATA_SIZE   (DATA_SIZE),
        .ADDR_SIZE   (ADDR_SIZE),
        .PORTS_NUM   (PORTS_NUM),
        .NODES_NUM   (NODES_NUM),
        .MAX_PKT_LEN (MAX_PKT_LEN),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .a_rst_n      (a_rst_n),
        .mem_empty    (mem_empty),
        .data_i       (data_i),
        .port_conn    (port_conn),
        .r_ready_in   (r_ready_in),
        .mem_readed   (mem_readed),
        .wr_ready_out (wr_ready_out),
        .data_o       (data_o),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    // Input queue model: head is q[pops], popped on each mem_readed cycle
    assign mem_empty = (pops >= qlen);
    assign data_i    = q[pops[5:0]];

    always @(posedge clk) begin
        if (mem_readed) pops <= pops + 1;
        if ($countones(wr_ready_out) > 1) multi_hot <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [BUS-1:0] mk(int unsigned dest, bit tail, logic [31:0] pl);
        return {pl, tail, ADDR_SIZE'(dest)};
    endfunction

    function automatic logic [BUS-1:0] slice(int unsigned p);
        return data_o[p*BUS +: BUS];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [BUS-1:0] f);
        q[qlen[5:0]] = f;
        qlen = qlen + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance at least one cycle, then until some valid is high (bounded)
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        tick();
        while (wr_ready_out == '0 && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 64'(wr_ready_out != '0), 64'(1));
    endtask

    logic [BUS-1:0] f1, f2, f3, f4, f5;
    int             p0;

    initial begin
        for (int i = 0; i < 64; i++) q[i] = '0;
        a_rst_n    = 1'b0;
        port_conn  = '1;
        r_ready_in = '0;

        // Reset values
        tick(); tick();
        chk("rst_wr",     64'(wr_ready_out), 64'(0));
        chk("rst_data",   64'(data_o != '0), 64'(0));
        chk("rst_busy",   64'(busy), 64'(0));
        chk("rst_readed", 64'(mem_readed), 64'(0));
        chk("rst_drop",   64'(drop_err), 64'(0));
        a_rst_n = 1'b1;
        tick();

        // Single-flit packet to own address, immediate ack
        r_ready_in = '1;
        f1 = mk(0, 1'b1, 32'hA5A5_0001);
        p0 = pops;
        push(f1);
        tick();
        chk("t2_busy_e1", 64'(busy), 64'(1));
        chk("t2_wr_e1",   64'(wr_ready_out), 64'(0));
        tick();
        chk("t2_wr_e2",   64'(wr_ready_out), 64'(0));
        tick();
        chk("t2_wr_e3",     64'(wr_ready_out), 64'(5'b10000));
        chk("t2_data_e3",   64'(slice(4)), 64'(f1));
        chk("t2_readed_e3", 64'(mem_readed), 64'(1));
        tick();
        chk("t2_wr_e4",     64'(wr_ready_out), 64'(0));
        chk("t2_busy_e4",   64'(busy), 64'(0));
        chk("t2_readed_e4", 64'(mem_readed), 64'(0));
        chk("t2_pops",      64'(pops - p0), 64'(1));

        // 3-flit packet to port 1, ack delayed 5 cycles, foreign acks high
        r_ready_in = 5'b11101;
        f1 = mk(1, 1'b0, 32'h1111_0001);
        f2 = mk(1, 1'b0, 32'h1111_0002);
        f3 = mk(1, 1'b1, 32'h1111_0003);
        p0 = pops;
        push(f1); push(f2); push(f3);
        wait_valid("t3_f1");
        chk("t3_f1_wr",   64'(wr_ready_out), 64'(5'b00010));
        chk("t3_f1_data", 64'(slice(1)), 64'(f1));
        repeat (5) tick();
        chk("t3_f1_hold", 64'(wr_ready_out), 64'(5'b00010));
        r_ready_in = 5'b11111; tick(); r_ready_in = 5'b11101;
        chk("t3_f1_ack",  64'(wr_ready_out), 64'(0));
        wait_valid("t3_f2");
        chk("t3_f2_wr",   64'(wr_ready_out), 64'(5'b00010));
        chk("t3_f2_data", 64'(slice(1)), 64'(f2));
        repeat (5) tick();
        chk("t3_f2_hold", 64'(wr_ready_out), 64'(5'b00010));
        r_ready_in = 5'b11111; tick(); r_ready_in = 5'b11101;
        wait_valid("t3_f3");
        chk("t3_f3_wr",   64'(wr_ready_out), 64'(5'b00010));
        chk("t3_f3_data", 64'(slice(1)), 64'(f3));
        repeat (5) tick();
        r_ready_in = 5'b11111; tick();
        chk("t3_busy_end", 64'(busy), 64'(0));
        chk("t3_pops",     64'(pops - p0), 64'(3));
        chk("t3_port0",    64'(slice(0)), 64'(0));
        chk("t3_port2",    64'(slice(2)), 64'(0));

        // Head to port 2 with its link down -> reflected to local port
        port_conn = 5'b11011;
        f1 = mk(3, 1'b0, 32'h2222_0001);
        f2 = mk(3, 1'b1, 32'h2222_0002);
        push(f1); push(f2);
        wait_valid("t4_f1");
        chk("t4_f1_wr",   64'(wr_ready_out), 64'(5'b10000));
        chk("t4_f1_data", 64'(slice(4)), 64'(f1));
        wait_valid("t4_f2");
        chk("t4_f2_wr",   64'(wr_ready_out), 64'(5'b10000));
        chk("t4_f2_data", 64'(slice(4)), 64'(f2));
        tick();
        chk("t4_busy_end", 64'(busy), 64'(0));
        chk("t4_port2",    64'(slice(2)), 64'(0));
        port_conn = '1;

        // Link drop mid-packet does not move the lock
        f1 = mk(2, 1'b0, 32'h3333_0001);
        f2 = mk(2, 1'b1, 32'h3333_0002);
        push(f1); push(f2);
        wait_valid("t5_f1");
        chk("t5_f1_wr", 64'(wr_ready_out), 64'(5'b00010));
        port_conn = 5'b11101;
        wait_valid("t5_f2");
        chk("t5_f2_wr",   64'(wr_ready_out), 64'(5'b00010));
        chk("t5_f2_data", 64'(slice(1)), 64'(f2));
        tick();
        port_conn = '1;

        // Destination outside the mesh -> local port
        f1 = mk(12, 1'b1, 32'h4444_0001);
        push(f1);
        wait_valid("t6_f1");
        chk("t6_wr",   64'(wr_ready_out), 64'(5'b10000));
        chk("t6_data", 64'(slice(4)), 64'(f1));
        tick();

        // Length limit 3 on a 5-flit packet; remainder re-routed from flit 4
        f1 = mk(1, 1'b0, 32'h5555_0001);
        f2 = mk(1, 1'b0, 32'h5555_0002);
        f3 = mk(1, 1'b0, 32'h5555_0003);
        f4 = mk(3, 1'b0, 32'h5555_0004);
        f5 = mk(3, 1'b1, 32'h5555_0005);
        push(f1); push(f2); push(f3); push(f4); push(f5);
        wait_valid("t7_f1");
        wait_valid("t7_f2");
        wait_valid("t7_f3");
        chk("t7_f3_wr",   64'(wr_ready_out), 64'(5'b00010));
        chk("t7_f3_data", 64'(slice(1)), 64'(f3));
        chk("t7_no_drop_yet", 64'(drop_err), 64'(0));
        tick();
        chk("t7_drop",      64'(drop_err), 64'(1));
        chk("t7_busy_drop", 64'(busy), 64'(0));
        chk("t7_wr_drop",   64'(wr_ready_out), 64'(0));
        tick();
        chk("t7_drop_pulse", 64'(drop_err), 64'(0));
        chk("t7_busy_new",   64'(busy), 64'(1));
        wait_valid("t7_f4");
        chk("t7_f4_wr",   64'(wr_ready_out), 64'(5'b00100));
        chk("t7_f4_data", 64'(slice(2)), 64'(f4));
        wait_valid("t7_f5");
        chk("t7_f5_wr",   64'(wr_ready_out), 64'(5'b00100));
        chk("t7_f5_data", 64'(slice(2)), 64'(f5));
        tick();
        chk("t7_busy_end", 64'(busy), 64'(0));
        chk("t7_drop_end", 64'(drop_err), 64'(0));

        // Ack timeout, or indefinite wait when the timer is absent
        r_ready_in = 5'b11101;
        f1 = mk(1, 1'b1, 32'h6666_0001);
        push(f1);
        wait_valid("t9_f1");
        chk("t9_wr", 64'(wr_ready_out), 64'(5'b00010));
`ifdef PKT_TX_TIMEOUT_EN
        repeat (TIMEOUT - 1) tick();
        chk("t9_wr_before_to", 64'(wr_ready_out), 64'(5'b00010));
        tick();
        chk("t9_wr_to",   64'(wr_ready_out), 64'(0));
        chk("t9_drop_to", 64'(drop_err), 64'(1));
        chk("t9_busy_to", 64'(busy), 64'(0));
        tick();
        chk("t9_drop_pulse", 64'(drop_err), 64'(0));
        chk("t9_idle",       64'(busy), 64'(0));
`else
        repeat (20) tick();
        chk("t9_wr_hold",   64'(wr_ready_out), 64'(5'b00010));
        chk("t9_busy_hold", 64'(busy), 64'(1));
        chk("t9_no_drop",   64'(drop_err), 64'(0));
        r_ready_in = 5'b11111; tick();
        chk("t9_wr_ack", 64'(wr_ready_out), 64'(0));
`endif

        // Reset in the middle of ACK on port 1
        r_ready_in = 5'b11101;
        f1 = mk(1, 1'b1, 32'h7777_0001);
        push(f1);
        wait_valid("t8_f1");
        chk("t8_wr_pre", 64'(wr_ready_out), 64'(5'b00010));
        #1 a_rst_n = 1'b0;
        #1;
        chk("t8_wr_rst",     64'(wr_ready_out), 64'(0));
        chk("t8_data_rst",   64'(data_o != '0), 64'(0));
        chk("t8_busy_rst",   64'(busy), 64'(0));
        chk("t8_readed_rst", 64'(mem_readed), 64'(0));
        qlen = pops;
        tick(); tick();
        a_rst_n = 1'b1;
        repeat (3) tick();
        chk("t8_wr_idle",   64'(wr_ready_out), 64'(0));
        chk("t8_busy_idle", 64'(busy), 64'(0));

        chk("one_hot_valid", 64'(multi_hot), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
